// File: rtl/galaxian_pkg.sv
// Shared widths, ROM region map and loader state type for the Galaxian ROM loader.
package galaxian_pkg;

  localparam int unsigned ADDR_W  = 25;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned INDEX_W = 8;
  localparam int unsigned WADDR_W = 14;
  localparam int unsigned COUNT_W = 16;

  // Region bases in the download address space
  localparam int unsigned PGM_BASE   = 32'h0000;
  localparam int unsigned GFX_K_BASE = 32'h4000;
  localparam int unsigned GFX_H_BASE = 32'h5000;
  localparam int unsigned PAL_BASE   = 32'h6000;

  localparam int unsigned PGM_SIZE = 16384;
  localparam int unsigned GFX_SIZE = 4096;
  localparam int unsigned PAL_SIZE = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2,
    ST_RUN  = 2'd3
  } loader_state_e;

endpackage

// File: rtl/strobe_edge.sv
// Registered rising-edge detector: rise_c is high in the first cycle a strobe is seen high.
module strobe_edge (
  input  logic clk,
  input  logic res_n,
  input  logic strobe,
  output logic rise_c
);

  logic strobe_q;

  always_ff @(posedge clk) begin
    if (!res_n) begin
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= strobe;
    end
  end

  assign rise_c = strobe && !strobe_q;

endmodule

// File: rtl/galaxian_rom_loader.sv
// Galaxian ROM loader: steers data_io download bytes into the program, graphics and
// palette ROM regions and keeps the game core in reset until the image is in place.
module galaxian_rom_loader
  import galaxian_pkg::*;
#(
  parameter int unsigned        PGM_BYTES   = PGM_SIZE,
  parameter int unsigned        GFX_BYTES   = GFX_SIZE,
  parameter int unsigned        PAL_BYTES   = PAL_SIZE,
  parameter int unsigned        HOLD_CYCLES = 16,
  parameter logic [INDEX_W-1:0] ROM_INDEX   = 8'h00
) (
  input  logic               clk_sys,
  input  logic               res_n,
  input  logic               ioctl_download,
  input  logic [INDEX_W-1:0] ioctl_index,
  input  logic               ioctl_wr,
  input  logic [ADDR_W-1:0]  ioctl_addr,
  input  logic [DATA_W-1:0]  ioctl_dout,
  output logic               pgm_we,
  output logic               gfx_k_we,
  output logic               gfx_h_we,
  output logic               pal_we,
  output logic [WADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0]  wr_data,
  output logic               core_reset,
  output logic               load_done,
  output logic               load_error,
  output logic [COUNT_W-1:0] byte_count
);

  localparam logic [ADDR_W-1:0]  PGM_HI     = ADDR_W'(PGM_BASE + PGM_BYTES);
  localparam logic [ADDR_W-1:0]  K_LO       = ADDR_W'(GFX_K_BASE);
  localparam logic [ADDR_W-1:0]  K_HI       = ADDR_W'(GFX_K_BASE + GFX_BYTES);
  localparam logic [ADDR_W-1:0]  H_LO       = ADDR_W'(GFX_H_BASE);
  localparam logic [ADDR_W-1:0]  H_HI       = ADDR_W'(GFX_H_BASE + GFX_BYTES);
  localparam logic [ADDR_W-1:0]  PAL_LO     = ADDR_W'(PAL_BASE);
  localparam logic [ADDR_W-1:0]  PAL_HI     = ADDR_W'(PAL_BASE + PAL_BYTES);
  localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(PAL_BASE + PAL_BYTES);
  localparam int unsigned        HOLD_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);

  loader_state_e state, state_next;

  logic [HOLD_W-1:0]  hold_cnt;
  logic               rise_c;
  logic               qualify;
  logic               accept, good, bad;
  logic               sel_pgm, sel_k, sel_h, sel_pal, in_range;
  logic [WADDR_W-1:0] offset;
  logic [COUNT_W-1:0] count_inc, count_after;
  logic               load_entry, hold_entry, run_entry;

  strobe_edge u_strobe_edge (
    .clk    (clk_sys),
    .res_n  (res_n),
    .strobe (ioctl_wr),
    .rise_c (rise_c)
  );

  assign qualify = ioctl_download && (ioctl_index == ROM_INDEX);

  always_ff @(posedge clk_sys) begin
    if (!res_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A restart in HOLD or RUN goes straight back to LOAD; HOLD lasts HOLD_CYCLES cycles.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (qualify) state_next = ST_LOAD;
      ST_LOAD: if (!ioctl_download) state_next = ST_HOLD;
      ST_HOLD: begin
        if (qualify) begin
          state_next = ST_LOAD;
        end else if (hold_cnt == HOLD_LAST) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN:  if (qualify) state_next = ST_LOAD;
      default: state_next = ST_IDLE;
    endcase
  end

  // Region decode; the priority chain guarantees at most one select.
  always_comb begin
    sel_pgm = 1'b0;
    sel_k   = 1'b0;
    sel_h   = 1'b0;
    sel_pal = 1'b0;
    offset  = '0;
    if (ioctl_addr < PGM_HI) begin
      sel_pgm = 1'b1;
      offset  = WADDR_W'(ioctl_addr);
    end else if ((ioctl_addr >= K_LO) && (ioctl_addr < K_HI)) begin
      sel_k  = 1'b1;
      offset = WADDR_W'(ioctl_addr - K_LO);
    end else if ((ioctl_addr >= H_LO) && (ioctl_addr < H_HI)) begin
      sel_h  = 1'b1;
      offset = WADDR_W'(ioctl_addr - H_LO);
    end else if ((ioctl_addr >= PAL_LO) && (ioctl_addr < PAL_HI)) begin
      sel_pal = 1'b1;
      offset  = WADDR_W'(ioctl_addr - PAL_LO);
    end
  end

  // A strobe edge is taken whenever the state is LOAD, even if download falls that cycle.
  always_comb begin
    in_range    = sel_pgm || sel_k || sel_h || sel_pal;
    accept      = (state == ST_LOAD) && rise_c;
    good        = accept && in_range;
    bad         = accept && !in_range;
    count_inc   = (byte_count == '1) ? byte_count : byte_count + COUNT_W'(1);
    count_after = good ? count_inc : byte_count;
    load_entry  = (state_next == ST_LOAD) && (state != ST_LOAD);
    hold_entry  = (state == ST_LOAD) && (state_next == ST_HOLD);
    run_entry   = (state == ST_HOLD) && (state_next == ST_RUN);
  end

  always_ff @(posedge clk_sys) begin
    if (!res_n) begin
      pgm_we     <= 1'b0;
      gfx_k_we   <= 1'b0;
      gfx_h_we   <= 1'b0;
      pal_we     <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      byte_count <= '0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      core_reset <= 1'b1;
      hold_cnt   <= '0;
    end else begin
      pgm_we   <= good && sel_pgm;
      gfx_k_we <= good && sel_k;
      gfx_h_we <= good && sel_h;
      pal_we   <= good && sel_pal;
      if (good) begin
        wr_addr <= offset;
        wr_data <= ioctl_dout;
      end
      byte_count <= load_entry ? '0 : count_after;
      // Error covers stray addresses and an image that ended short.
      if (load_entry) begin
        load_error <= 1'b0;
      end else if (bad || (hold_entry && (count_after < FULL_COUNT))) begin
        load_error <= 1'b1;
      end
      if (load_entry) begin
        load_done <= 1'b0;
      end else if (run_entry) begin
        load_done <= 1'b1;
      end
      core_reset <= (state_next != ST_RUN);
      hold_cnt   <= ((state == ST_HOLD) && (state_next == ST_HOLD)) ? hold_cnt + HOLD_W'(1) : '0;
    end
  end

endmodule

// File: tb/tb_galaxian_rom_loader.sv
// Bench for galaxian_rom_loader: expected writes are queued as bytes are driven and
// matched against the enable pulses; status outputs are checked per scenario.
module tb_galaxian_rom_loader;

  logic        clk_sys = 1'b0;
  logic        res_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        pgm_we, gfx_k_we, gfx_h_we, pal_we;
  logic [13:0] wr_addr;
  logic [7:0]  wr_data;
  logic        core_reset, load_done, load_error;
  logic [15:0] byte_count;

  typedef struct {
    logic [1:0]  kind;
    logic [13:0] waddr;
    logic [7:0]  data;
  } wr_exp_t;

  wr_exp_t     exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          n_pgm, n_k, n_h, n_pal;
  logic [15:0] exp_count;
  logic        exp_done, exp_error;

  always #5 clk_sys = ~clk_sys;

  galaxian_rom_loader dut (
    .clk_sys        (clk_sys),
    .res_n          (res_n),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .pgm_we         (pgm_we),
    .gfx_k_we       (gfx_k_we),
    .gfx_h_we       (gfx_h_we),
    .pal_we         (pal_we),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .core_reset     (core_reset),
    .load_done      (load_done),
    .load_error     (load_error),
    .byte_count     (byte_count)
  );

  function automatic logic [7:0] pat(input logic [24:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Reference address map: kind 0=pgm, 1=gfx 1K, 2=gfx 1H, 3=palette.
  function automatic bit decode(input logic [24:0] a, output logic [1:0] kind,
                                output logic [13:0] waddr);
    kind  = 2'd0;
    waddr = 14'h0;
    if (a < 25'h4000) begin
      waddr = a[13:0];
      return 1'b1;
    end
    if (a < 25'h5000) begin
      kind = 2'd1; waddr = {2'b0, a[11:0]};
      return 1'b1;
    end
    if (a < 25'h6000) begin
      kind = 2'd2; waddr = {2'b0, a[11:0]};
      return 1'b1;
    end
    if (a < 25'h6020) begin
      kind = 2'd3; waddr = {9'b0, a[4:0]};
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic start_download(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    if (idx == 8'h00) begin
      exp_count = 16'h0;
      exp_error = 1'b0;
      exp_done  = 1'b0;
    end
    step();
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input int hold,
                           input bit in_load);
    logic [1:0]  k;
    logic [13:0] w;
    bit          ok;
    ok = decode(a, k, w);
    if (in_load && ok) begin
      exp_q.push_back('{kind: k, waddr: w, data: d});
      if (exp_count != 16'hFFFF) exp_count++;
    end
    if (in_load && !ok) exp_error = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    repeat (hold) step();
    ioctl_wr = 1'b0;
    step();
  endtask

  task automatic wait_run(output int cycles);
    cycles = 0;
    while (core_reset !== 1'b0 && cycles < 64) begin
      step();
      cycles++;
    end
  endtask

  // Scoreboard consumer: every enable pulse must match the oldest queued byte.
  task automatic monitor();
    wr_exp_t    e;
    int         n;
    logic [1:0] k;
    forever begin
      @(negedge clk_sys);
      n = $countones({pgm_we, gfx_k_we, gfx_h_we, pal_we});
      if (n != 0) begin
        k = pgm_we ? 2'd0 : gfx_k_we ? 2'd1 : gfx_h_we ? 2'd2 : 2'd3;
        case (k)
          2'd0: n_pgm++;
          2'd1: n_k++;
          2'd2: n_h++;
          default: n_pal++;
        endcase
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL write_unexpected: got kind=%0d addr=%h data=%h, required no write",
                   k, wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          if (n != 1 || k !== e.kind || wr_addr !== e.waddr || wr_data !== e.data) begin
            miscompares++;
            $display("FAIL write_payload: got enables=%0d kind=%0d addr=%h data=%h, required 1 kind=%0d addr=%h data=%h",
                     n, k, wr_addr, wr_data, e.kind, e.waddr, e.data);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    res_n = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'h00;
    ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
    exp_count = '0; exp_done = 1'b0; exp_error = 1'b0;
    repeat (3) step();
    vectors++;
    if ({pgm_we, gfx_k_we, gfx_h_we, pal_we, wr_addr, wr_data} !== 26'h0) begin
      miscompares++;
      $display("FAIL reset_write_port: got we=%b%b%b%b addr=%h data=%h, required all zero",
               pgm_we, gfx_k_we, gfx_h_we, pal_we, wr_addr, wr_data);
    end
    vectors++;
    if ({byte_count, load_done, load_error, core_reset} !== {16'h0, 1'b0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_status: got count=%h done=%b err=%b core_reset=%b, required 0000 0 0 1",
               byte_count, load_done, load_error, core_reset);
    end
    res_n = 1'b1;
    repeat (3) step();
    vectors++;
    if (core_reset !== 1'b1 || load_done !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_status: got core_reset=%b done=%b, required 1 0", core_reset, load_done);
    end
  endtask

  task automatic test_reset_mid_download();
    start_download(8'h00);
    for (int a = 'h1F00; a <= 'h2000; a++) send_byte(25'(a), pat(25'(a)), 1, 1'b1);
    vectors++;
    if (byte_count !== exp_count) begin
      miscompares++;
      $display("FAIL pre_reset_count: got %h, required %h", byte_count, exp_count);
    end
    res_n = 1'b0;
    step();
    vectors++;
    if ({pgm_we, gfx_k_we, gfx_h_we, pal_we, wr_addr, wr_data, byte_count, load_done, load_error, core_reset}
        !== {26'h0, 16'h0, 1'b0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL mid_reset_values: got we=%b%b%b%b addr=%h data=%h count=%h done=%b err=%b core_reset=%b, required zeros and core_reset=1",
               pgm_we, gfx_k_we, gfx_h_we, pal_we, wr_addr, wr_data, byte_count, load_done,
               load_error, core_reset);
    end
    step();
    res_n     = 1'b1;
    exp_count = 16'h0;
    exp_error = 1'b0;
    exp_done  = 1'b0;
    step();
    vectors++;
    if ({byte_count, core_reset, load_done} !== {16'h0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL post_reset_reload: got count=%h core_reset=%b done=%b, required 0000 1 0",
               byte_count, core_reset, load_done);
    end
  endtask

  task automatic test_full_image();
    int cyc;
    n_pgm = 0; n_k = 0; n_h = 0; n_pal = 0;
    for (int a = 0; a < 'h6020; a++) send_byte(25'(a), pat(25'(a)), (a % 7 == 0) ? 2 : 1, 1'b1);
    ioctl_download = 1'b0;
    step();
    vectors++;
    if ({load_error, load_done, core_reset} !== 3'b001) begin
      miscompares++;
      $display("FAIL full_hold_entry: got err=%b done=%b core_reset=%b, required 0 0 1",
               load_error, load_done, core_reset);
    end
    wait_run(cyc);
    vectors++;
    if (cyc != 16) begin
      miscompares++;
      $display("FAIL full_hold_cycles: got %0d, required 16", cyc);
    end
    exp_done = 1'b1;
    vectors++;
    if ({byte_count, load_done, load_error, core_reset} !== {16'h6020, exp_done, exp_error, 1'b0}) begin
      miscompares++;
      $display("FAIL full_status: got count=%h done=%b err=%b core_reset=%b, required 6020 1 0 0",
               byte_count, load_done, load_error, core_reset);
    end
    vectors++;
    if (n_pgm != 16384 || n_k != 4096 || n_h != 4096 || n_pal != 32 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL full_region_counts: got pgm=%0d k=%0d h=%0d pal=%0d pending=%0d, required 16384 4096 4096 32 0",
               n_pgm, n_k, n_h, n_pal, exp_q.size());
    end
  endtask

  task automatic test_held_strobe();
    int cyc;
    start_download(8'h00);
    vectors++;
    if ({load_done, core_reset} !== 2'b01) begin
      miscompares++;
      $display("FAIL restart_entry: got done=%b core_reset=%b, required 0 1", load_done, core_reset);
    end
    exp_q.push_back('{kind: 2'd2, waddr: 14'h0003, data: 8'hA5});
    exp_count  = 16'h1;
    ioctl_addr = 25'h5003;
    ioctl_dout = 8'hA5;
    ioctl_wr   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_sys);
      vectors++;
      if (i == 1) begin
        if ({pgm_we, gfx_k_we, gfx_h_we, pal_we, wr_addr, wr_data} !== {4'b0010, 14'h0003, 8'hA5}) begin
          miscompares++;
          $display("FAIL held_pulse: got we=%b%b%b%b addr=%h data=%h, required 0010 0003 a5",
                   pgm_we, gfx_k_we, gfx_h_we, pal_we, wr_addr, wr_data);
        end
      end else if ({pgm_we, gfx_k_we, gfx_h_we, pal_we} !== 4'b0000) begin
        miscompares++;
        $display("FAIL held_no_repeat: cycle %0d got we=%b%b%b%b, required 0000",
                 i, pgm_we, gfx_k_we, gfx_h_we, pal_we);
      end
      step();
    end
    ioctl_wr = 1'b0;
    step();
    ioctl_download = 1'b0;
    step();
    wait_run(cyc);
    exp_error = 1'b1;
    exp_done  = 1'b1;
    vectors++;
    if ({cyc[7:0], byte_count, load_done, load_error} !== {8'd16, exp_count, exp_done, exp_error}) begin
      miscompares++;
      $display("FAIL held_status: got cycles=%0d count=%h done=%b err=%b, required 16 %h 1 1",
               cyc, byte_count, load_done, load_error, exp_count);
    end
  endtask

  task automatic test_short_image();
    int cyc;
    start_download(8'h00);
    for (int a = 'h3F00; a <= 'h3FFF; a++) send_byte(25'(a), pat(25'(a)), 1 + (a & 1), 1'b1);
    ioctl_download = 1'b0;
    step();
    exp_error = 1'b1;
    vectors++;
    if ({load_error, load_done, core_reset} !== 3'b101) begin
      miscompares++;
      $display("FAIL short_hold_entry: got err=%b done=%b core_reset=%b, required 1 0 1",
               load_error, load_done, core_reset);
    end
    wait_run(cyc);
    vectors++;
    if (cyc != 16) begin
      miscompares++;
      $display("FAIL short_hold_cycles: got %0d, required 16", cyc);
    end
    exp_done = 1'b1;
    vectors++;
    if ({byte_count, load_done, load_error, core_reset} !== {16'h0100, exp_done, exp_error, 1'b0}) begin
      miscompares++;
      $display("FAIL short_status: got count=%h done=%b err=%b core_reset=%b, required 0100 1 1 0",
               byte_count, load_done, load_error, core_reset);
    end
  endtask

  task automatic test_out_of_range();
    int cyc;
    logic [24:0] good_addrs [5];
    good_addrs = '{25'h601F, 25'h6000, 25'h4FFF, 25'h5000, 25'h0000};
    start_download(8'h00);
    foreach (good_addrs[i]) send_byte(good_addrs[i], pat(good_addrs[i]), 1, 1'b1);
    vectors++;
    if ({byte_count, load_error} !== {exp_count, 1'b0}) begin
      miscompares++;
      $display("FAIL range_edges: got count=%h err=%b, required %h 0", byte_count, load_error, exp_count);
    end
    send_byte(25'h6020, 8'h11, 1, 1'b1);
    vectors++;
    if ({byte_count, load_error} !== {exp_count, 1'b1}) begin
      miscompares++;
      $display("FAIL range_6020: got count=%h err=%b, required %h 1", byte_count, load_error, exp_count);
    end
    send_byte(25'h7000, 8'h22, 1, 1'b1);
    vectors++;
    if ({byte_count, load_error} !== {exp_count, 1'b1}) begin
      miscompares++;
      $display("FAIL range_7000: got count=%h err=%b, required %h 1", byte_count, load_error, exp_count);
    end
    send_byte(25'h1234, 8'h33, 1, 1'b1);
    ioctl_download = 1'b0;
    step();
    wait_run(cyc);
    exp_done = 1'b1;
    vectors++;
    if ({byte_count, load_done, load_error, core_reset} !== {16'h0006, exp_done, exp_error, 1'b0}) begin
      miscompares++;
      $display("FAIL range_status: got count=%h done=%b err=%b core_reset=%b, required 0006 1 1 0",
               byte_count, load_done, load_error, core_reset);
    end
  endtask

  task automatic test_foreign_index();
    start_download(8'h01);
    for (int a = 0; a < 100; a++) begin
      send_byte(25'(a), pat(25'(a)), 1, 1'b0);
      if (a % 25 == 24) begin
        vectors++;
        if ({byte_count, load_done, load_error, core_reset} !== {exp_count, exp_done, exp_error, 1'b0}) begin
          miscompares++;
          $display("FAIL foreign_status: byte %0d got count=%h done=%b err=%b core_reset=%b, required %h %b %b 0",
                   a, byte_count, load_done, load_error, core_reset, exp_count, exp_done, exp_error);
        end
      end
    end
    ioctl_download = 1'b0;
    ioctl_index    = 8'h00;
    repeat (20) step();
    vectors++;
    if (core_reset !== 1'b0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL foreign_after: got core_reset=%b pending=%0d, required 0 0", core_reset, exp_q.size());
    end
  endtask

  task automatic test_last_byte_on_fall();
    int cyc;
    start_download(8'h00);
    for (int a = 'h10; a < 'h20; a++) send_byte(25'(a), pat(25'(a)), 1, 1'b1);
    exp_q.push_back('{kind: 2'd0, waddr: 14'h0020, data: 8'h6C});
    exp_count++;
    ioctl_addr     = 25'h0020;
    ioctl_dout     = 8'h6C;
    ioctl_wr       = 1'b1;
    ioctl_download = 1'b0;
    step();
    ioctl_wr = 1'b0;
    wait_run(cyc);
    exp_error = 1'b1;
    exp_done  = 1'b1;
    vectors++;
    if ({cyc[7:0], byte_count, load_done, load_error} !== {8'd16, 16'h0011, exp_done, exp_error}) begin
      miscompares++;
      $display("FAIL last_byte_status: got cycles=%0d count=%h done=%b err=%b, required 16 0011 1 1",
               cyc, byte_count, load_done, load_error);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL last_byte_written: got %0d pending writes, required 0", exp_q.size());
    end
  endtask

  task automatic test_hold_restart();
    int cyc;
    start_download(8'h00);
    for (int a = 'h4000; a < 'h4008; a++) send_byte(25'(a), pat(25'(a)), 1, 1'b1);
    ioctl_download = 1'b0;
    step();
    repeat (5) step();
    vectors++;
    if ({load_error, core_reset} !== 2'b11) begin
      miscompares++;
      $display("FAIL restart_in_hold: got err=%b core_reset=%b, required 1 1", load_error, core_reset);
    end
    start_download(8'h00);
    vectors++;
    if ({byte_count, load_error, load_done, core_reset} !== {16'h0, 1'b0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL restart_cleared: got count=%h err=%b done=%b core_reset=%b, required 0000 0 0 1",
               byte_count, load_error, load_done, core_reset);
    end
    for (int a = 'h6000; a < 'h6004; a++) send_byte(25'(a), pat(25'(a)), 1, 1'b1);
    ioctl_download = 1'b0;
    step();
    wait_run(cyc);
    exp_error = 1'b1;
    exp_done  = 1'b1;
    vectors++;
    if ({cyc[7:0], byte_count, load_done, load_error} !== {8'd16, 16'h0004, exp_done, exp_error}) begin
      miscompares++;
      $display("FAIL restart_status: got cycles=%0d count=%h done=%b err=%b, required 16 0004 1 1",
               cyc, byte_count, load_done, load_error);
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_reset_mid_download();
    test_full_image();
    test_held_strobe();
    test_short_image();
    test_out_of_range();
    test_foreign_index();
    test_last_byte_on_fall();
    test_hold_restart();
    repeat (4) step();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending writes, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
